chain_delay_meter: RTL and testbench

- Controller and reader for the inverter-chain delay sensor.
- Drives the chain's enable and launch inputs, then samples the chain output through a synchronizer.
- Counts clock cycles from launching an edge until that edge emerges at the chain output, giving a coarse delay measurement.
- Sits between the chain instance and the debugger's sensor register block. Results leave on a valid/ready handshake.

---
 rtl/chain_delay_meter_pkg.sv | 14 +
 rtl/chain_delay_meter_sync.sv | 21 ++
 rtl/chain_delay_meter.sv | 169 ++++++++++++++++
 tb/tb_chain_delay_meter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chain_delay_meter_pkg.sv
// Shared types for the inverter-chain delay meter.
// State encoding and synchronizer depth used by the top and the bench.
package chain_delay_meter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      RUN,
      DONE
   } state_t;

   localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/chain_delay_meter_sync.sv
// Multi-flop synchronizer for the asynchronous chain output.
// Depth set by STAGES (minimum 2); clears to 0 on reset.
module chain_delay_meter_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ff <= '0;
      else        ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/chain_delay_meter.sv
// Inverter-chain delay meter: settles, launches an edge, counts cycles to arrival.
// Optional multi-pass averaging when CHAIN_DELAY_METER_AVG_EN is defined.
module chain_delay_meter
   import chain_delay_meter_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int SETTLE_CYC  = 64,
   parameter int TIMEOUT_CYC = 4095,
   parameter int OUT_INVERTS = 0
`ifdef CHAIN_DELAY_METER_AVG_EN
   ,
   parameter int AVG_LOG2    = 3
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   output logic             busy_o,
   output logic             chain_en_o,
   output logic             launch_o,
   input  logic             chain_out_i,
   output logic [CNT_W-1:0] result_o,
   output logic             result_valid_o,
   input  logic             result_ready_i,
   output logic             timeout_o,
   output logic             baseline_err_o
);

   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam logic [SW-1:0]    SET_LAST = SW'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] SYNC_LAT = CNT_W'(SYNC_STAGES);
   localparam logic             IDLE_LVL = (OUT_INVERTS != 0);

   state_t           state_q, state_d;
   logic [SW-1:0]    settle_q, settle_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] result_q, result_d;
   logic             tout_q, tout_d;
   logic             berr_q, berr_d;
   logic             sync_q;
   logic [CNT_W-1:0] pass_res;

`ifdef CHAIN_DELAY_METER_AVG_EN
   localparam int AW = CNT_W + AVG_LOG2;
   localparam int PW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [PW-1:0] PASS_LAST = PW'((1 << AVG_LOG2) - 1);

   logic [AW-1:0] acc_q, acc_d, acc_sum;
   logic [PW-1:0] pass_q, pass_d;

   assign acc_sum = acc_q + AW'(pass_res);
`endif

   chain_delay_meter_sync #(
      .STAGES(SYNC_STAGES)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (chain_out_i),
      .q    (sync_q)
   );

   // Remove synchronizer latency, never going below zero
   assign pass_res = (cnt_q >= SYNC_LAT) ? (cnt_q - SYNC_LAT) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         settle_q <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         tout_q   <= 1'b0;
         berr_q   <= 1'b0;
`ifdef CHAIN_DELAY_METER_AVG_EN
         acc_q    <= '0;
         pass_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         tout_q   <= tout_d;
         berr_q   <= berr_d;
`ifdef CHAIN_DELAY_METER_AVG_EN
         acc_q    <= acc_d;
         pass_q   <= pass_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      tout_d   = tout_q;
      berr_d   = berr_q;
`ifdef CHAIN_DELAY_METER_AVG_EN
      acc_d    = acc_q;
      pass_d   = pass_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               tout_d   = 1'b0;
               berr_d   = 1'b0;
               settle_d = '0;
               state_d  = SETTLE;
`ifdef CHAIN_DELAY_METER_AVG_EN
               acc_d    = '0;
               pass_d   = '0;
`endif
            end
         end
         SETTLE: begin
            settle_d = settle_q + SW'(1);
            if (settle_q == SET_LAST) begin
               if (sync_q != IDLE_LVL) begin
                  berr_d   = 1'b1;
                  result_d = '0;
                  state_d  = DONE;
               end else begin
                  cnt_d   = '0;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            cnt_d = cnt_q + CNT_W'(1);
            // Arrival is checked first so it wins over a same-cycle timeout
            if (sync_q != IDLE_LVL) begin
`ifdef CHAIN_DELAY_METER_AVG_EN
               if (pass_q == PASS_LAST) begin
                  result_d = CNT_W'(acc_sum >> AVG_LOG2);
                  state_d  = DONE;
               end else begin
                  acc_d    = acc_sum;
                  pass_d   = pass_q + PW'(1);
                  settle_d = '0;
                  state_d  = SETTLE;
               end
`else
               result_d = pass_res;
               state_d  = DONE;
`endif
            end else if (cnt_q == TMO) begin
               tout_d   = 1'b1;
               result_d = '1;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (result_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_o         = (state_q != IDLE);
   assign chain_en_o     = (state_q != IDLE);
   assign launch_o       = (state_q == RUN);
   assign result_valid_o = (state_q == DONE);
   assign result_o       = result_q;
   assign timeout_o      = tout_q;
   assign baseline_err_o = berr_q;

endmodule

// File: tb/tb_chain_delay_meter.sv
// Self-checking bench for chain_delay_meter with a delay-line chain model.
// Per-measurement schedule model plus literal pins on key results.
module tb_chain_delay_meter;

   localparam int TMO = 100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        ready = 1'b0;
   logic        chain_out = 1'b0;
   logic        busy, en, launch, valid, tout, berr;
   logic [15:0] result;

   chain_delay_meter #(
      .CNT_W(16),
      .SETTLE_CYC(64),
      .TIMEOUT_CYC(TMO),
      .OUT_INVERTS(0)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start_i(start),
      .busy_o(busy),
      .chain_en_o(en),
      .launch_o(launch),
      .chain_out_i(chain_out),
      .result_o(result),
      .result_valid_o(valid),
      .result_ready_i(ready),
      .timeout_o(tout),
      .baseline_err_o(berr)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // chain mode: 0 delay line, 1 inverting delay line, 2 stuck low
   int mode = 0;
   int dly = 7;
   logic [127:0] hist = '0;

   logic [1:0]  q[$];
   bit          pend = 0;
   logic [15:0] m_res = '0, o_res = '0;
   bit          m_tout = 0, m_berr = 0, o_tout = 0, o_berr = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_busy", busy, 0);
         chk("rst_en", en, 0);
         chk("rst_launch", launch, 0);
         chk("rst_valid", valid, 0);
         chk("rst_result", result, 0);
         chk("rst_flags", {tout, berr}, 0);
         q.delete();
         pend = 0;
         m_res = '0;
         m_tout = 0;
         m_berr = 0;
      end else begin
         if (q.size() > 0) begin
            chk("busy", busy, 1);
            chk("en", en, q[0][1]);
            chk("launch", launch, q[0][0]);
            chk("valid", valid, 0);
            chk("flags", {tout, berr}, 0);
         end else begin
            chk("busy", busy, pend);
            chk("en", en, pend);
            chk("launch", launch, 0);
            chk("valid", valid, pend);
            chk("result", result, m_res);
            chk("flags", {tout, berr}, {m_tout, m_berr});
         end
         if (q.size() > 0) begin
            void'(q.pop_front());
            if (q.size() == 0) begin
               pend = 1;
               m_res = o_res;
               m_tout = o_tout;
               m_berr = o_berr;
            end
         end else if (pend) begin
            if (ready) pend = 0;
         end else if (start) begin
            m_tout = 0;
            m_berr = 0;
            o_tout = 0;
            o_berr = 0;
            for (int i = 0; i < 64; i++) q.push_back(2'b10);
            if (mode == 1) begin
               o_res = '0;
               o_berr = 1;
            end else if (mode == 0 && dly + 2 <= TMO) begin
               for (int i = 0; i < dly + 3; i++) q.push_back(2'b11);
               o_res = 16'(dly);
            end else begin
               for (int i = 0; i < TMO + 1; i++) q.push_back(2'b11);
               o_res = 16'hFFFF;
               o_tout = 1;
            end
         end
      end
      hist = {hist[126:0], launch};
      chain_out = (mode == 2) ? 1'b0 : ((mode == 1) ^ hist[dly]);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic measure(input int md, input int d, input int lat,
                          input bit noise, input bit early,
                          output logic [15:0] r, output bit t, output bit b,
                          output int sc, output int rc, output bit sl);
      bit got;
      mode = md;
      dly = d;
      start = 0;
      ready = 0;
      repeat (d + 6) tick();
      start = 1;
      tick();
      start = 0;
      ready = early;
      sc = 0;
      rc = 0;
      sl = 0;
      got = 0;
      r = '0;
      t = 0;
      b = 0;
      for (int i = 0; i < 600 && !got; i++) begin
         if (valid) got = 1;
         else begin
            if (launch) begin
               rc++;
               sl = 1;
            end else if (busy && !sl) sc++;
            start = noise && (i == 10);
            tick();
         end
      end
      start = 0;
      if (!got) begin
         chk("valid_wait", 0, 1);
         ready = 0;
         return;
      end
      r = result;
      t = tout;
      b = berr;
      if (!early) begin
         for (int k = 0; k < lat; k++) begin
            start = noise && (k % 3 == 1);
            tick();
            chk("hold_res", result, r);
            chk("hold_valid", valid, 1);
         end
         start = 0;
         ready = 1;
      end
      tick();
      ready = 0;
      chk("valid_drop", valid, 0);
      chk("idle_after", busy, 0);
   endtask

   logic [15:0] r;
   bit t, b, sl;
   int sc, rc;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("init_busy", busy, 0);
      chk("init_valid", valid, 0);
      chk("init_result", result, 0);
      rst_n = 1;
      tick();

      measure(0, 7, 0, 0, 0, r, t, b, sc, rc, sl);
      chk("d7_res", r, 7);
      chk("d7_tout", t, 0);
      chk("d7_settle", sc, 64);
      chk("d7_run", rc, 10);

      measure(1, 7, 1, 0, 0, r, t, b, sc, rc, sl);
      chk("base_err", b, 1);
      chk("base_res", r, 0);
      chk("base_launch", sl, 0);

      measure(2, 7, 0, 0, 1, r, t, b, sc, rc, sl);
      chk("tmo_flag", t, 1);
      chk("tmo_res", r, 16'hFFFF);
      chk("tmo_run", rc, 101);

      measure(0, 98, 0, 0, 0, r, t, b, sc, rc, sl);
      chk("d98_res", r, 98);
      chk("d98_tout", t, 0);
      measure(0, 99, 0, 0, 0, r, t, b, sc, rc, sl);
      chk("d99_tout", t, 1);
      measure(0, 0, 0, 0, 1, r, t, b, sc, rc, sl);
      chk("d0_res", r, 0);
      measure(0, 5, 20, 1, 0, r, t, b, sc, rc, sl);
      chk("d5_res", r, 5);

      mode = 0;
      dly = 7;
      repeat (15) tick();
      start = 1;
      tick();
      start = 0;
      for (int i = 0; i < 200 && !launch; i++) tick();
      chk("mid_launch", launch, 1);
      repeat (2) tick();
      rst_n = 0;
      #1;
      chk("mid_en", en, 0);
      chk("mid_launch_drop", launch, 0);
      chk("mid_busy", busy, 0);
      tick();
      rst_n = 1;
      measure(0, 7, 2, 0, 0, r, t, b, sc, rc, sl);
      chk("post_rst_res", r, 7);

      for (int n = 0; n < 15; n++) begin
         int sel;
         sel = $urandom_range(0, 9);
         measure((sel == 0) ? 1 : (sel == 1) ? 2 : 0,
                 $urandom_range(0, 20), $urandom_range(0, 4),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 r, t, b, sc, rc, sl);
      end

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
